screen_fill_arbiter: RTL and testbench

- Shares the single read/write port of the 8192x16 screen framebuffer between two requesters: the Hack CPU and a hardware fill engine.
- The fill engine writes a constant 16-bit pattern across a contiguous word range, for clear-screen and rectangle-band fills.
- The CPU has absolute priority. The fill engine only uses cycles in which the CPU is not accessing the screen.
- Sits between the CPU memory-map decode and the screen framebuffer, in the CPU clock domain.

---
 rtl/screen_fill_arbiter_pkg.sv | 15 +
 rtl/screen_fill_arbiter_if.sv | 47 ++++
 rtl/screen_fill_arbiter_port_mux.sv | 31 +++
 rtl/screen_fill_arbiter.sv | 97 +++++++++
 tb/tb_screen_fill_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/screen_fill_arbiter_pkg.sv
// Shared constants and FSM encoding for the screen framebuffer port arbiter.
package screen_fill_arbiter_pkg;

  localparam int SCR_ADDR_W = 13;
  localparam int SCR_DATA_W = 16;
  localparam int SCR_LEN_W  = 14;
  localparam int SCR_WORDS  = 8192;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/screen_fill_arbiter_if.sv
// CPU, fill-engine and framebuffer signals of the screen port arbiter.
interface screen_fill_arbiter_if
  import screen_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W = SCR_ADDR_W,
  parameter int DATA_W = SCR_DATA_W,
  parameter int LEN_W  = SCR_LEN_W
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              fill_start;
  logic              fill_abort;
  logic [ADDR_W-1:0] fill_base;
  logic [LEN_W-1:0]  fill_len;
  logic [DATA_W-1:0] fill_pattern;
  logic              fill_busy;
  logic              fill_done;

  logic              scr_load;
  logic [ADDR_W-1:0] scr_address;
  logic [DATA_W-1:0] scr_in;
  logic [DATA_W-1:0] scr_out;

  // master drives requests and the framebuffer read data; slave is the arbiter
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output fill_start, fill_abort, fill_base, fill_len, fill_pattern,
    output scr_out,
    input  cpu_rdata, cpu_rvalid, fill_busy, fill_done,
    input  scr_load, scr_address, scr_in
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  fill_start, fill_abort, fill_base, fill_len, fill_pattern,
    input  scr_out,
    output cpu_rdata, cpu_rvalid, fill_busy, fill_done,
    output scr_load, scr_address, scr_in
  );

endinterface

// File: rtl/screen_fill_arbiter_port_mux.sv
// Combinational select of the framebuffer port: CPU first, fill engine on idle cycles.
module screen_port_mux #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  output logic              scr_load,
  output logic [ADDR_W-1:0] scr_address,
  output logic [DATA_W-1:0] scr_in
);

  always_comb begin
    scr_load    = 1'b0;
    scr_address = cpu_addr;
    scr_in      = cpu_wdata;
    if (cpu_req) begin
      scr_load = cpu_we;
    end else if (fill_en) begin
      scr_load    = 1'b1;
      scr_address = fill_addr;
      scr_in      = fill_data;
    end
  end

endmodule

// File: rtl/screen_fill_arbiter.sv
// Shares the screen framebuffer port between the CPU (absolute priority) and a
// constant-pattern fill engine that writes one word per CPU-idle cycle.
module screen_fill_arbiter
  import screen_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W = SCR_ADDR_W,
  parameter int DATA_W = SCR_DATA_W,
  parameter int LEN_W  = SCR_LEN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  screen_fill_arbiter_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              rvalid_q;
  logic [LEN_W-1:0]  len_sat;
  logic              fill_wr;

  // longer requests would revisit words; clamp to one full screen
  assign len_sat = (bus.fill_len > MAX_LEN) ? MAX_LEN : bus.fill_len;
  assign fill_wr = (state_q == RUN) && !bus.cpu_req;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          if (len_sat == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            ptr_d   = bus.fill_base;
            cnt_d   = len_sat;
            pat_d   = bus.fill_pattern;
          end
        end
      end
      RUN: begin
        if (fill_wr) begin
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q - LEN_W'(1);
        end
        if (bus.fill_abort || (fill_wr && cnt_q == LEN_W'(1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      pat_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      rvalid_q <= bus.cpu_req && !bus.cpu_we;
    end
  end

  assign bus.fill_busy  = (state_q != IDLE);
  assign bus.fill_done  = (state_q == DONE);
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_rdata  = bus.scr_out;

  // reset gates the fill write so a fill dropped by reset issues nothing more
  screen_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .cpu_req     (bus.cpu_req),
    .cpu_we      (bus.cpu_we),
    .cpu_addr    (bus.cpu_addr),
    .cpu_wdata   (bus.cpu_wdata),
    .fill_en     ((state_q == RUN) && !reset),
    .fill_addr   (ptr_q),
    .fill_data   (pat_q),
    .scr_load    (bus.scr_load),
    .scr_address (bus.scr_address),
    .scr_in      (bus.scr_in)
  );

endmodule

// File: tb/tb_screen_fill_arbiter.sv
// Bench for screen_fill_arbiter: fill-job table, hand-written corner sequences and
// randomized CPU/fill traffic against a queue-based reference model.
module tb_screen_fill_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  screen_fill_arbiter_if bus ();

  screen_fill_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // framebuffer: write on load, registered read with 1-cycle latency
  logic [15:0] fb [8192];
  always @(posedge clk) begin
    if (bus.scr_load) fb[bus.scr_address] <= bus.scr_in;
    bus.scr_out <= fb[bus.scr_address];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // reference model: pending fill addresses as a queue, expected memory as shadow
  logic [15:0] shd [8192];
  int          m_q[$];
  logic        m_run = 1'b0, m_done = 1'b0, m_rv = 1'b0;
  logic [15:0] m_pat = '0, m_rd = '0;

  logic        obs_load, obs_busy, obs_done, obs_rv, obs_req;
  logic [12:0] obs_addr;
  logic [15:0] obs_in, obs_rd;

  task automatic cycle();
    logic        e_load;
    logic [12:0] e_addr;
    logic [15:0] e_in;
    int          n;
    @(negedge clk);
    obs_load = bus.scr_load;   obs_addr = bus.scr_address; obs_in = bus.scr_in;
    obs_busy = bus.fill_busy;  obs_done = bus.fill_done;
    obs_rv   = bus.cpu_rvalid; obs_rd   = bus.cpu_rdata;   obs_req = bus.cpu_req;
    if (bus.cpu_req) begin
      e_load = bus.cpu_we; e_addr = bus.cpu_addr; e_in = bus.cpu_wdata;
    end else if (m_run && !reset) begin
      e_load = 1'b1; e_addr = 13'(m_q[0]); e_in = m_pat;
    end else begin
      e_load = 1'b0; e_addr = bus.cpu_addr; e_in = bus.cpu_wdata;
    end
    chk("scr_load", obs_load, e_load);
    chk("scr_address", obs_addr, e_addr);
    chk("scr_in", obs_in, e_in);
    chk("fill_busy", obs_busy, m_run | m_done);
    chk("fill_done", obs_done, m_done);
    chk("cpu_rvalid", obs_rv, m_rv);
    if (m_rv) chk("cpu_rdata", obs_rd, m_rd);
    m_rd = shd[bus.cpu_addr];
    if (e_load) shd[e_addr] = e_in;
    if (reset) begin
      m_run = 1'b0; m_done = 1'b0; m_rv = 1'b0; m_q.delete();
    end else begin
      m_rv = bus.cpu_req & ~bus.cpu_we;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_run) begin
        if (!bus.cpu_req) void'(m_q.pop_front());
        if (bus.fill_abort || m_q.size() == 0) begin
          m_run = 1'b0; m_done = 1'b1; m_q.delete();
        end
      end else if (bus.fill_start) begin
        n = (int'(bus.fill_len) > 8192) ? 8192 : int'(bus.fill_len);
        if (n == 0) m_done = 1'b1;
        else begin
          for (int i = 0; i < n; i++) m_q.push_back((int'(bus.fill_base) + i) % 8192);
          m_run = 1'b1; m_pat = bus.fill_pattern;
        end
      end
    end
    @(posedge clk); #1;
    bus.fill_start = 1'b0; bus.fill_abort = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; reset = 1'b0;
  endtask

  task automatic start_fill(input logic [12:0] b, input logic [13:0] l, input logic [15:0] p);
    bus.fill_start = 1'b1; bus.fill_base = b; bus.fill_len = l; bus.fill_pattern = p;
  endtask

  task automatic rand_cpu();
    bus.cpu_req   = ($urandom_range(0, 2) == 0);
    bus.cpu_we    = 1'($urandom_range(0, 1));
    bus.cpu_addr  = ($urandom_range(0, 1) == 0) ? 13'($urandom)
                                                : 13'(bus.fill_base + 13'($urandom_range(0, 40)));
    bus.cpu_wdata = 16'($urandom);
  endtask

  typedef struct {
    logic [12:0] base;
    logic [13:0] len;
    logic [15:0] pat;
    int          exp_writes;
    int          exp_done_at;
  } fill_vec_t;

  fill_vec_t tbl[5];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr, dn, done_at, bad;
    tbl[0] = '{13'd0,    14'd8192,  16'h0000, 8192, 8193};
    tbl[1] = '{13'd1,    14'd16383, 16'hC3C3, 8192, 8193};
    tbl[2] = '{13'd8190, 14'd4,     16'hA5A5, 4,    5};
    tbl[3] = '{13'd100,  14'd10,    16'h5A5A, 10,   11};
    tbl[4] = '{13'd50,   14'd0,     16'hFFFF, 0,    1};

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.fill_start = 0; bus.fill_abort = 0; bus.fill_base = 0; bus.fill_len = 0;
    bus.fill_pattern = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.fill_busy, 1'b0);
    chk("rst_done", bus.fill_done, 1'b0);
    chk("rst_rvalid", bus.cpu_rvalid, 1'b0);
    chk("rst_load", bus.scr_load, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      start_fill(tbl[i].base, tbl[i].len, tbl[i].pat);
      cycle();
      wr = 0; dn = 0; done_at = -1;
      for (int k = 1; k <= tbl[i].exp_done_at + 2; k++) begin
        cycle();
        if (obs_load) wr++;
        if (obs_done) begin dn++; if (done_at < 0) done_at = k; end
      end
      chk($sformatf("vec%0d_writes", i), wr, tbl[i].exp_writes);
      chk($sformatf("vec%0d_done_at", i), done_at, tbl[i].exp_done_at);
      chk($sformatf("vec%0d_done_pulses", i), dn, 1);
    end
    chk("wrap_8190", fb[8190], 16'hA5A5);
    chk("wrap_1", fb[1], 16'hA5A5);
    chk("wrap_word2_kept", fb[2], 16'hC3C3);
    chk("wrap_8189_kept", fb[8189], 16'hC3C3);

    // CPU writes in fill cycles 3 and 4 stall the fill by two cycles
    start_fill(13'd100, 14'd10, 16'h0F0F);
    cycle();
    wr = 0; done_at = -1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 3 || k == 4) begin
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 13'd5000; bus.cpu_wdata = 16'h1234;
      end
      cycle();
      if (obs_load && !obs_req) wr++;
      if (k == 3) chk("ilv_cpu_addr", obs_addr, 13'd5000);
      if (obs_done && done_at < 0) done_at = k;
    end
    chk("ilv_fill_writes", wr, 10);
    chk("ilv_done_at", done_at, 13);
    bad = 0;
    for (int a = 100; a < 110; a++) if (fb[a] !== 16'h0F0F) bad++;
    chk("ilv_range_bad", bad, 0);
    chk("ilv_cpu_word", fb[5000], 16'h1234);

    // CPU read mid-fill
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 13'd7; bus.cpu_wdata = 16'hBEEF;
    cycle();
    start_fill(13'd200, 14'd6, 16'h1111);
    cycle();
    done_at = -1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) begin bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 13'd7; end
      cycle();
      if (k == 2) chk("rd_no_fill_write", obs_load, 1'b0);
      if (k == 3) begin
        chk("rd_rvalid", obs_rv, 1'b1);
        chk("rd_rdata", obs_rd, 16'hBEEF);
      end
      if (obs_done && done_at < 0) done_at = k;
    end
    chk("rd_done_at", done_at, 8);

    // second start while running is ignored
    start_fill(13'd300, 14'd5, 16'h2222);
    cycle();
    done_at = -1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) start_fill(13'd400, 14'd5, 16'h3333);
      cycle();
      if (obs_done && done_at < 0) done_at = k;
    end
    chk("ign_done_at", done_at, 6);
    chk("ign_304", fb[304], 16'h2222);
    chk("ign_305", fb[305], 16'hC3C3);
    chk("ign_400", fb[400], 16'hC3C3);

    // start and abort together in IDLE: start wins
    start_fill(13'd700, 14'd2, 16'h4444);
    bus.fill_abort = 1;
    cycle();
    wr = 0; done_at = -1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (obs_load) wr++;
      if (obs_done && done_at < 0) done_at = k;
    end
    chk("sa_writes", wr, 2);
    chk("sa_done_at", done_at, 3);

    // abort during the third write cycle
    start_fill(13'd500, 14'd10, 16'h5555);
    cycle();
    wr = 0; done_at = -1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) bus.fill_abort = 1;
      cycle();
      if (obs_load) wr++;
      if (obs_done && done_at < 0) done_at = k;
    end
    chk("abt_writes", wr, 3);
    chk("abt_done_at", done_at, 4);
    chk("abt_502", fb[502], 16'h5555);
    chk("abt_503", fb[503], 16'hC3C3);

    // reset mid-fill
    start_fill(13'd600, 14'd20, 16'h6666);
    cycle();
    wr = 0; dn = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 5) reset = 1;
      cycle();
      if (obs_load) wr++;
      if (obs_done) dn++;
      if (k == 6) chk("rst_mid_busy", obs_busy, 1'b0);
    end
    chk("rst_mid_writes", wr, 4);
    chk("rst_mid_done", dn, 0);
    chk("rst_mid_603", fb[603], 16'h6666);
    chk("rst_mid_604", fb[604], 16'hC3C3);

    // randomized fills with random CPU traffic
    for (int t = 0; t < 30; t++) begin
      for (int g = 0; g < int'($urandom_range(1, 6)); g++) begin
        rand_cpu();
        cycle();
      end
      start_fill(13'($urandom), ($urandom_range(0, 9) == 0) ? 14'd0 : 14'($urandom_range(1, 40)),
                 16'($urandom));
      rand_cpu();
      cycle();
      for (int k = 0; k < 300 && (m_run || m_done); k++) begin
        rand_cpu();
        if ($urandom_range(0, 60) == 0) bus.fill_abort = 1;
        if ($urandom_range(0, 15) == 0) start_fill(13'($urandom), 14'd7, 16'hDEAD);
        cycle();
      end
      chk("rand_fill_finished", m_run | m_done, 1'b0);
    end
    cycle();

    bad = 0;
    for (int a = 0; a < 8192; a++) if (fb[a] !== shd[a]) bad++;
    chk("final_memory_bad_words", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
